// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory unit.
// FSM state enum, word width and default geometry/timing.
package mem_pkg;

  localparam int WORD_W = 32;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DEPTH = 512;
  localparam int MEM_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ram_sync.sv
// ram_sync: single-port RAM, sync write, one-cycle registered read.
// Ports: clk, we, re, addr, wdata -> rdata (holds between reads).
module ram_sync
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: wait-state memory controller (IDLE/WAIT/ACCESS/DONE).
// Ports: clk, clr, Read, Write, address, data_in -> Mdatain,
// MDready, busy; fault only when MEM_BOUNDS_EN is defined.
module mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH = MEM_DEPTH,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] Mdatain,
  output logic              MDready,
`ifdef MEM_BOUNDS_EN
  output logic              fault,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_ACC  = 2'(ST_ACCESS);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] mdata_q;
  logic [WORD_W-1:0] rdata;
  logic              wr_q;
  logic              fault_q;
  logic              oob;
  logic              req;
  logic              we;
  logic              re;

  assign req = Read | Write;

`ifdef MEM_BOUNDS_EN
  assign oob = int'(addr_q) >= DEPTH;
  assign fault = fault_q;
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= data_in;
            // Write wins when both are requested.
            wr_q    <= Write;
            if (WAIT_CYCLES == 0) begin
              state <= S_ACC;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_ACC;
          else cnt <= cnt - 4'd1;
        end
        S_ACC: begin
          state   <= S_DONE;
          fault_q <= oob;
        end
        default: begin
          state   <= S_IDLE;
          fault_q <= 1'b0;
          if (!wr_q && !fault_q) mdata_q <= rdata;
        end
      endcase
    end
  end

  // clr on the ACCESS edge must still suppress the write.
  assign we = (state == S_ACC) && wr_q && !oob && !clr;
  assign re = (state == S_ACC) && !wr_q && !oob && !clr;

  ram_sync #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  // RAM output is live in DONE; afterwards the held copy drives out.
  assign Mdatain = (state == S_DONE && !wr_q && !fault_q)
                 ? rdata : mdata_q;
  assign MDready = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed, table-driven bench for mem_unit.
// Define MEM_BOUNDS_EN to also exercise the range check.
module tb_mem_unit;

  localparam int WC = 1;
`ifdef MEM_BOUNDS_EN
  localparam int DP = 256;
`else
  localparam int DP = 512;
`endif

  logic        clk;
  logic        clr;
  logic        Read;
  logic        Write;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] Mdatain;
  logic        MDready;
  logic        busy;
`ifdef MEM_BOUNDS_EN
  logic        fault;
`endif

  int checks = 0;
  int errors = 0;

  mem_unit #(
    .ADDR_W     (9),
    .DEPTH      (DP),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .Read   (Read),
    .Write  (Write),
    .address(address),
    .data_in(data_in),
    .Mdatain(Mdatain),
    .MDready(MDready),
`ifdef MEM_BOUNDS_EN
    .fault  (fault),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // One access; request sampled at the next posedge.
  task automatic acc(input logic rd, input logic wr,
                     input logic [8:0] a,
                     input logic [31:0] d,
                     output int lat,
                     output logic [31:0] md,
                     output logic flt);
    @(negedge clk);
    Read = rd;
    Write = wr;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
    Read = 1'b0;
    Write = 1'b0;
    lat = 0;
    while (!MDready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    md = Mdatain;
`ifdef MEM_BOUNDS_EN
    flt = fault;
`else
    flt = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  int lat;
  int pulses;
  logic [31:0] md;
  logic flt;

  initial begin
    vt[0]  = '{0, 1, 9'h012, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1, 0, 9'h012, 32'h0, 32'hDEADBEEF};
    vt[2]  = '{1, 1, 9'h005, 32'h00000042, 32'hDEADBEEF};
    vt[3]  = '{1, 0, 9'h005, 32'h0, 32'h00000042};
    vt[4]  = '{0, 1, 9'h0FF, 32'h12345678, 32'h00000042};
    vt[5]  = '{1, 0, 9'h0FF, 32'h0, 32'h12345678};
    vt[6]  = '{0, 1, 9'h000, 32'hA5A5A5A5, 32'h12345678};
    vt[7]  = '{1, 0, 9'h000, 32'h0, 32'hA5A5A5A5};
    vt[8]  = '{0, 1, 9'h001, 32'h11111111, 32'hA5A5A5A5};
    vt[9]  = '{0, 1, 9'h020, 32'h0BADF00D, 32'hA5A5A5A5};
    vt[10] = '{1, 0, 9'h012, 32'h0, 32'hDEADBEEF};
    vt[11] = '{1, 0, 9'h020, 32'h0, 32'h0BADF00D};

    Read = 0;
    Write = 0;
    address = '0;
    data_in = '0;
    clr = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mdata", Mdatain, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rdy", {31'b0, MDready}, 32'h0);
    @(negedge clk);
    clr = 0;

    for (int i = 0; i < 12; i++) begin
      acc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data,
          lat, md, flt);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(WC + 1));
      chk($sformatf("v%0d_data", i), md, vt[i].exp);
      chk($sformatf("v%0d_idle", i),
          {30'b0, busy, MDready}, 32'h0);
    end

    // Request while busy is dropped.
    @(negedge clk);
    Read = 1;
    address = 9'h001;
    @(posedge clk);
    #1;
    Read = 0;
    Write = 1;
    data_in = 32'h1;
    chk("busy_wait", {31'b0, busy}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) Write = 0;
      if (MDready) pulses++;
      @(posedge clk);
      #1;
    end
    chk("busy_pulses", 32'(pulses), 32'd1);
    chk("busy_mdata", Mdatain, 32'h11111111);
    acc(1, 0, 9'h001, 32'h0, lat, md, flt);
    chk("busy_wr_drop", md, 32'h11111111);

    // clr in WAIT aborts a write.
    @(negedge clk);
    Write = 1;
    address = 9'h020;
    data_in = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    Write = 0;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    chk("abw_busy", {31'b0, busy}, 32'h0);
    chk("abw_mdata", Mdatain, 32'h0);
    acc(1, 0, 9'h020, 32'h0, lat, md, flt);
    chk("abw_read", md, 32'h0BADF00D);

    // clr on the ACCESS edge aborts too.
    @(negedge clk);
    Write = 1;
    address = 9'h020;
    data_in = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    Write = 0;
    repeat (WC) @(posedge clk);
    #1;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    chk("aba_rdy", {30'b0, busy, MDready}, 32'h0);
    acc(1, 0, 9'h020, 32'h0, lat, md, flt);
    chk("aba_read", md, 32'h0BADF00D);

    // Held request re-sampled after each DONE.
    @(negedge clk);
    Read = 1;
    address = 9'h005;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (MDready) pulses++;
    end
    Read = 0;
    chk("hold_pulses", 32'(pulses), 32'd3);
    chk("hold_mdata", Mdatain, 32'h00000042);
    @(posedge clk);
    #1;
    chk("hold_idle", {31'b0, busy}, 32'h0);

`ifdef MEM_BOUNDS_EN
    acc(1, 0, 9'h1FF, 32'h0, lat, md, flt);
    chk("oob_lat", 32'(lat), 32'(WC + 1));
    chk("oob_fault", {31'b0, flt}, 32'h1);
    chk("oob_mdata", md, 32'h00000042);
    chk("oob_after", {31'b0, fault}, 32'h0);
    acc(1, 0, 9'h0FF, 32'h0, lat, md, flt);
    chk("inb_fault", {31'b0, flt}, 32'h0);
    chk("inb_data", md, 32'h12345678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
